output_manager_queued: RTL and testbench

- Parametrised successor to the scheduler-driven output manager.
- Turns scheduler events (batch complete, layer complete) into output packets for the PS. Each packet is a 6-word header followed by a READ trigger to the parser/BRAM readout path.
- Adds over the previous generation:
  - an event queue, so events arriving during a transfer are not lost;
  - a valid/ready serial header stream;
  - selectable notification BRAM;
  - generic BRAM count and depth;
  - overflow and packet-count status.

---
 rtl/output_pkg.sv | 44 ++++
 rtl/om_event_fifo.sv | 88 ++++++++
 rtl/output_manager_queued.sv | 167 ++++++++++++++++
 tb/tb_output_manager_queued.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_pkg.sv
// Shared constants, FSM encoding and header-word helper for the output manager.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package output_pkg;

  localparam logic [15:0] MAGIC_NOTIF = 16'hC0DE;
  localparam logic [15:0] MAGIC_FULL  = 16'hDA7A;
  localparam logic [15:0] TYPE_NOTIF  = 16'h0001;
  localparam logic [15:0] TYPE_FULL   = 16'h0002;

  localparam int HDR_WORDS = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_TRIG = 2'd2,
    ST_WAIT = 2'd3
  } om_state_e;

  // Header word idx of a packet. All arithmetic is done at 32 bits and
  // truncated to 16 so oversized products wrap rather than saturate.
  function automatic logic [15:0] hdr_word(
    input logic        is_full,
    input logic [15:0] id,
    input logic [2:0]  idx,
    input int          tiles,
    input int          num_bram,
    input int          depth
  );
    logic [15:0] w;
    w = '0;
    case (idx)
      3'd0: w = is_full ? MAGIC_FULL : MAGIC_NOTIF;
      3'd1: w = is_full ? TYPE_FULL : TYPE_NOTIF;
      3'd2: w = id;
      3'd3: w = is_full ? 16'h0000 : 16'(32'(id) * 32'(tiles));
      3'd4: w = is_full ? 16'h0000 : 16'(32'(id) * 32'(tiles) + 32'(tiles) - 32'd1);
      3'd5: w = is_full ? 16'(32'(num_bram) * 32'(depth)) : 16'(depth);
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/om_event_fifo.sv
// Event queue: up to two pushes and one pop per cycle, sticky overflow on dropped pushes.
// Latency: a push is visible at head/empty the cycle after it is sampled.
// Backpressure: none upstream; pushes beyond the free slots (counted before this cycle's pop) are dropped.
//   ports: clk, rst_n; push0_vld/push0_dat (ordered first), push1_vld/push1_dat;
//          pop (ignored when empty); head_dat, empty, overflow (sticky).
module om_event_fifo #(
  parameter int QDEPTH = 4,
  parameter int EW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push0_vld,
  input  logic [EW-1:0] push0_dat,
  input  logic          push1_vld,
  input  logic [EW-1:0] push1_dat,
  input  logic          pop,
  output logic [EW-1:0] head_dat,
  output logic          empty,
  output logic          overflow
);

  localparam int AW = $clog2(QDEPTH);

  logic [EW-1:0] mem_q [QDEPTH];
  logic [EW-1:0] mem_d [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   free_slots;
  logic [AW:0]   n_push;
  logic          do_pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    n_push     = '0;
    // Free space is judged on occupancy at the start of the cycle, so a
    // simultaneous pop does not make room for a push in the same cycle.
    free_slots = (AW+1)'(QDEPTH) - count_q;
    do_pop     = pop && (count_q != '0);

    if (push0_vld) begin
      if (n_push < free_slots) begin
        mem_d[wr_ptr_d] = push0_dat;
        wr_ptr_d        = wr_ptr_d + 1'b1;
        n_push          = n_push + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (push1_vld) begin
      if (n_push < free_slots) begin
        mem_d[wr_ptr_d] = push1_dat;
        wr_ptr_d        = wr_ptr_d + 1'b1;
        n_push          = n_push + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + n_push - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign overflow = ovf_q;

endmodule

// File: rtl/output_manager_queued.sv
// Turns queued scheduler events into a 6-word serial header plus one READ trigger per packet.
// Latency: event sampled at edge N is queued, popped at N+1, first header word valid after N+1.
// Backpressure: header held stable under hdr_ready low; events queue up while busy, excess dropped (queue_overflow).
//   ports: clk, rst_n; batch_complete/current_batch_id, all_batches_done/completed_layer_id (events);
//          hdr_data/hdr_valid/hdr_ready/hdr_last (header stream); trigger_read, rd_bram_start/end,
//          rd_addr_count, read_done (READ path); transmission_active, queue_overflow, pkt_count (status).
module output_manager_queued
  import output_pkg::*;
#(
  parameter  int NUM_BRAM        = 8,
  parameter  int BRAM_DEPTH      = 512,
  parameter  int BATCH_W         = 3,
  parameter  int LAYER_W         = 2,
  parameter  int TILES_PER_BATCH = 4,
  parameter  int QDEPTH          = 4,
  localparam int BW              = $clog2(NUM_BRAM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               batch_complete,
  input  logic [BATCH_W-1:0] current_batch_id,
  input  logic               all_batches_done,
  input  logic [LAYER_W-1:0] completed_layer_id,
  output logic [15:0]        hdr_data,
  output logic               hdr_valid,
  input  logic               hdr_ready,
  output logic               hdr_last,
  output logic               trigger_read,
  output logic [BW-1:0]      rd_bram_start,
  output logic [BW-1:0]      rd_bram_end,
  output logic [15:0]        rd_addr_count,
  input  logic               read_done,
  output logic               transmission_active,
  output logic               queue_overflow,
  output logic [15:0]        pkt_count
);

  localparam int IDW = (BATCH_W > LAYER_W) ? BATCH_W : LAYER_W;
  localparam int EW  = IDW + 1;

  logic [EW-1:0] push0_dat, push1_dat, head_dat;
  logic          fifo_empty, fifo_pop;

  // Entry layout {type, id}: type 0 = notification, 1 = full.
  assign push0_dat = {1'b0, IDW'(current_batch_id)};
  assign push1_dat = {1'b1, IDW'(completed_layer_id)};

  om_event_fifo #(
    .QDEPTH (QDEPTH),
    .EW     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push0_vld (batch_complete),
    .push0_dat (push0_dat),
    .push1_vld (all_batches_done),
    .push1_dat (push1_dat),
    .pop       (fifo_pop),
    .head_dat  (head_dat),
    .empty     (fifo_empty),
    .overflow  (queue_overflow)
  );

  om_state_e     state_q, state_d;
  logic [EW-1:0] cur_q, cur_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] rd_start_q, rd_start_d, rd_end_q, rd_end_d;
  logic [15:0]   rd_cnt_q, rd_cnt_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic          cur_full;
  logic [15:0]   cur_id;
  logic          last_beat;
  logic          hdr_fire;

  assign cur_full  = cur_q[EW-1];
  assign cur_id    = 16'(cur_q[IDW-1:0]);
  assign last_beat = (idx_q == 3'(HDR_WORDS - 1));
  assign hdr_fire  = (state_q == ST_HDR) && hdr_ready;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty)           state_d = ST_HDR;
      ST_HDR:  if (hdr_fire && last_beat) state_d = ST_TRIG;
      ST_TRIG:                            state_d = ST_WAIT;
      ST_WAIT: if (read_done)             state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    hdr_valid           = (state_q == ST_HDR);
    hdr_last            = (state_q == ST_HDR) && last_beat;
    trigger_read        = (state_q == ST_TRIG);
    transmission_active = (state_q != ST_IDLE);
    hdr_data            = '0;
    if (state_q == ST_HDR) begin
      hdr_data = hdr_word(cur_full, cur_id, idx_q, TILES_PER_BATCH, NUM_BRAM, BRAM_DEPTH);
    end
  end

  // Packet datapath: latched event, word index, READ config, packet counter.
  always_comb begin
    cur_d      = cur_q;
    idx_d      = idx_q;
    rd_start_d = rd_start_q;
    rd_end_d   = rd_end_q;
    rd_cnt_d   = rd_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;

    if (fifo_pop) begin
      cur_d = head_dat;
      idx_d = '0;
    end
    if (hdr_fire) begin
      idx_d = idx_q + 3'd1;
    end
    // Load the READ config on the way into TRIG so it is valid alongside
    // trigger_read and then simply held until the next packet.
    if (hdr_fire && last_beat) begin
      rd_cnt_d = 16'(BRAM_DEPTH);
      if (cur_full) begin
        rd_start_d = '0;
        rd_end_d   = BW'(NUM_BRAM - 1);
      end else begin
        rd_start_d = BW'(32'(cur_id) % 32'(NUM_BRAM));
        rd_end_d   = BW'(32'(cur_id) % 32'(NUM_BRAM));
      end
    end
    if ((state_q == ST_WAIT) && read_done) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= '0;
      idx_q      <= '0;
      rd_start_q <= '0;
      rd_end_q   <= '0;
      rd_cnt_q   <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      cur_q      <= cur_d;
      idx_q      <= idx_d;
      rd_start_q <= rd_start_d;
      rd_end_q   <= rd_end_d;
      rd_cnt_q   <= rd_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign rd_bram_start = rd_start_q;
  assign rd_bram_end   = rd_end_q;
  assign rd_addr_count = rd_cnt_q;
  assign pkt_count     = pkt_cnt_q;

endmodule

// File: tb/tb_output_manager_queued.sv
module tb_output_manager_queued;

  localparam int NUM_BRAM        = 8;
  localparam int BRAM_DEPTH      = 512;
  localparam int BATCH_W         = 3;
  localparam int LAYER_W         = 2;
  localparam int TILES_PER_BATCH = 4;
  localparam int QDEPTH          = 4;
  localparam int BW              = $clog2(NUM_BRAM);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               batch_complete;
  logic [BATCH_W-1:0] current_batch_id;
  logic               all_batches_done;
  logic [LAYER_W-1:0] completed_layer_id;
  logic [15:0]        hdr_data;
  logic               hdr_valid;
  logic               hdr_ready;
  logic               hdr_last;
  logic               trigger_read;
  logic [BW-1:0]      rd_bram_start;
  logic [BW-1:0]      rd_bram_end;
  logic [15:0]        rd_addr_count;
  logic               read_done;
  logic               transmission_active;
  logic               queue_overflow;
  logic [15:0]        pkt_count;

  output_manager_queued #(
    .NUM_BRAM        (NUM_BRAM),
    .BRAM_DEPTH      (BRAM_DEPTH),
    .BATCH_W         (BATCH_W),
    .LAYER_W         (LAYER_W),
    .TILES_PER_BATCH (TILES_PER_BATCH),
    .QDEPTH          (QDEPTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .batch_complete      (batch_complete),
    .current_batch_id    (current_batch_id),
    .all_batches_done    (all_batches_done),
    .completed_layer_id  (completed_layer_id),
    .hdr_data            (hdr_data),
    .hdr_valid           (hdr_valid),
    .hdr_ready           (hdr_ready),
    .hdr_last            (hdr_last),
    .trigger_read        (trigger_read),
    .rd_bram_start       (rd_bram_start),
    .rd_bram_end         (rd_bram_end),
    .rd_addr_count       (rd_addr_count),
    .read_done           (read_done),
    .transmission_active (transmission_active),
    .queue_overflow      (queue_overflow),
    .pkt_count           (pkt_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference model: pending events as a plain queue of {type, id}.
  logic [3:0] mq[$];
  logic [3:0] m_cur;
  bit         m_busy;
  bit         m_ovf;
  int         m_pkt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [3:0] e, input int k);
    int id;
    int v;
    id = int'(e[2:0]);
    if (e[3]) begin
      case (k)
        0: v = 'hDA7A;
        1: v = 2;
        2: v = id;
        3: v = 0;
        4: v = 0;
        default: v = (NUM_BRAM * BRAM_DEPTH) % 65536;
      endcase
    end else begin
      case (k)
        0: v = 'hC0DE;
        1: v = 1;
        2: v = id;
        3: v = id * TILES_PER_BATCH;
        4: v = id * TILES_PER_BATCH + TILES_PER_BATCH - 1;
        default: v = BRAM_DEPTH;
      endcase
    end
    return 16'(v);
  endfunction

  // Applies the event rules for one clock edge using the inputs held across it.
  function automatic void model_edge();
    int occ;
    int acc;
    bit do_pop;
    if (!rst_n) begin
      mq.delete();
      m_busy = 0;
      m_ovf  = 0;
      m_pkt  = 0;
      return;
    end
    occ    = mq.size();
    acc    = 0;
    do_pop = !m_busy && (occ > 0);
    if (batch_complete) begin
      if (occ + acc < QDEPTH) begin mq.push_back({1'b0, current_batch_id}); acc++; end
      else m_ovf = 1;
    end
    if (all_batches_done) begin
      if (occ + acc < QDEPTH) begin mq.push_back({1'b1, 1'b0, completed_layer_id}); acc++; end
      else m_ovf = 1;
    end
    if (do_pop) begin
      m_cur  = mq.pop_front();
      m_busy = 1;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_event(input bit b, input int bid, input bit a, input int lid);
    batch_complete     = b;
    current_batch_id   = BATCH_W'(bid);
    all_batches_done   = a;
    completed_layer_id = LAYER_W'(lid);
    cycle();
    batch_complete     = 0;
    all_batches_done   = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"},  32'(hdr_valid), 0);
    chk({tag, "_dat"},  32'(hdr_data), 0);
    chk({tag, "_last"}, 32'(hdr_last), 0);
    chk({tag, "_trig"}, 32'(trigger_read), 0);
    chk({tag, "_rds"},  32'(rd_bram_start), 0);
    chk({tag, "_rde"},  32'(rd_bram_end), 0);
    chk({tag, "_rdc"},  32'(rd_addr_count), 0);
    chk({tag, "_act"},  32'(transmission_active), 0);
    chk({tag, "_ovf"},  32'(queue_overflow), 0);
    chk({tag, "_pkt"},  32'(pkt_count), 0);
  endtask

  // Waits for hdr_valid, checks all 6 beats and the READ trigger; leaves DUT in WAIT.
  // lat >= 0 checks the number of cycles from the call to the first valid word.
  task automatic recv_hdr_trig(input bit gaps, input int lat);
    int waited;
    int g;
    logic [15:0] w;
    logic [3:0]  e;
    waited    = 0;
    hdr_ready = 0;
    while (!hdr_valid && waited < 40) begin
      cycle();
      waited++;
    end
    chk("hdr_vld_seen", 32'(hdr_valid), 1);
    if (!hdr_valid) return;
    if (lat >= 0) chk("first_hdr_lat", 32'(waited), 32'(lat));
    e = m_cur;
    for (int b = 0; b < 6; b++) begin
      w = exp_word(e, b);
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      hdr_ready = 0;
      for (int s = 0; s < g; s++) begin
        chk("stall_vld", 32'(hdr_valid), 1);
        chk("stall_dat", 32'(hdr_data), 32'(w));
        cycle();
      end
      hdr_ready = 1;
      chk("beat_vld",  32'(hdr_valid), 1);
      chk("beat_dat",  32'(hdr_data), 32'(w));
      chk("beat_last", 32'(hdr_last), (b == 5) ? 32'd1 : 32'd0);
      cycle();
    end
    hdr_ready = 0;
    chk("trig_hi",   32'(trigger_read), 1);
    chk("after6_vld", 32'(hdr_valid), 0);
    chk("rd_start", 32'(rd_bram_start), e[3] ? 32'd0 : 32'(int'(e[2:0]) % NUM_BRAM));
    chk("rd_end",   32'(rd_bram_end),   e[3] ? 32'(NUM_BRAM - 1) : 32'(int'(e[2:0]) % NUM_BRAM));
    chk("rd_count", 32'(rd_addr_count), 32'(BRAM_DEPTH));
    cycle();
    chk("trig_once", 32'(trigger_read), 0);
    chk("rd_hold",   32'(rd_bram_end), e[3] ? 32'(NUM_BRAM - 1) : 32'(int'(e[2:0]) % NUM_BRAM));
    chk("act_wait",  32'(transmission_active), 1);
  endtask

  task automatic finish_read();
    int d;
    d = int'($urandom_range(0, 2));
    for (int i = 0; i < d; i++) cycle();
    read_done = 1;
    cycle();
    read_done = 0;
    m_busy = 0;
    m_pkt++;
    chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
    chk("act_drop",  32'(transmission_active), 0);
  endtask

  task automatic drain(input bit gaps);
    int guard;
    guard = 0;
    while ((m_busy || mq.size() > 0) && guard < 12) begin
      recv_hdr_trig(gaps, -1);
      finish_read();
      guard++;
    end
    for (int i = 0; i < 3; i++) cycle();
    chk("drain_idle_vld", 32'(hdr_valid), 0);
    chk("drain_idle_act", 32'(transmission_active), 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; batch_complete = 0; current_batch_id = '0; all_batches_done = 0;
    completed_layer_id = '0; hdr_ready = 0; read_done = 0;
    cycle();
    cycle();
    chk_all_zero("reset");
    rst_n = 1;
    cycle();

    // 1: single notification, id 5, ready always high.
    drive_event(1, 5, 0, 0);
    chk("q_not_yet_vld", 32'(hdr_valid), 0);
    recv_hdr_trig(0, 1);
    finish_read();

    // read_done while idle is ignored.
    read_done = 1;
    cycle();
    read_done = 0;
    chk("stray_read_done", 32'(pkt_count), 32'(m_pkt));

    // 2: full packet, layer 2.
    drive_event(0, 0, 1, 2);
    recv_hdr_trig(0, 1);
    finish_read();

    // 3: random ready gaps on random notifications.
    for (int r = 0; r < 3; r++) begin
      drive_event(1, int'($urandom_range(0, 7)), 0, 0);
      recv_hdr_trig(1, 1);
      finish_read();
    end

    // 4: both events together; notification first, no overflow.
    drive_event(1, 1, 1, 0);
    drain(1);
    chk("same_cycle_ovf", 32'(queue_overflow), 0);

    // 5: six events while the first packet waits; four kept, rest dropped.
    drive_event(1, 6, 0, 0);
    recv_hdr_trig(0, 1);
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 0) drive_event(1, int'($urandom_range(0, 7)), 0, 0);
      else                           drive_event(0, 0, 1, int'($urandom_range(0, 3)));
    end
    chk("ovf_set", 32'(queue_overflow), 32'(m_ovf));
    finish_read();
    drain(1);
    chk("ovf_sticky", 32'(queue_overflow), 1);

    // Random event bursts checked against the model, then drained.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        drive_event(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
      drain(1);
      chk("rand_ovf", 32'(queue_overflow), 32'(m_ovf));
    end

    // 6: reset while beat 3 is presented, then a clean full packet.
    drive_event(1, 3, 0, 0);
    for (int i = 0; i < 10 && !hdr_valid; i++) cycle();
    hdr_ready = 1;
    for (int b = 0; b < 3; b++) begin
      chk("pre_rst_dat", 32'(hdr_data), 32'(exp_word(m_cur, b)));
      cycle();
    end
    hdr_ready = 0;
    chk("beat3_dat", 32'(hdr_data), 32'(exp_word(m_cur, 3)));
    #2;
    rst_n = 0;
    #1;
    mq.delete(); m_busy = 0; m_ovf = 0; m_pkt = 0;
    chk_all_zero("midrst");
    cycle();
    cycle();
    rst_n = 1;
    cycle();
    chk("post_rst_vld", 32'(hdr_valid), 0);
    drive_event(0, 0, 1, 3);
    recv_hdr_trig(0, 1);
    finish_read();
    chk("post_rst_pkt", 32'(pkt_count), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
